// File: rtl/ir_sirc_tx_if.sv
// rtl/ir_sirc_tx_if.sv - command/handshake bundle between robot command logic and the SIRC transmitter
interface ir_sirc_tx_if #(
  parameter int MAX_BITS = 20
);
  logic [MAX_BITS-1:0] data;
  logic [4:0]          nbits;
  logic [3:0]          repeats;
  logic                start;
  logic                ready;
  logic                busy;
  logic                done;

  modport master (
    output data, nbits, repeats, start,
    input  ready, busy, done
  );

  modport slave (
    input  data, nbits, repeats, start,
    output ready, busy, done
  );
endinterface

// File: rtl/ir_sirc_tx.sv
// rtl/ir_sirc_tx.sv - Sony SIRC IR frame transmitter, 1..MAX_BITS bits per frame with repeats
// Optional IR_SIRC_TX_HOLD_EN: start held at the end of the final gap keeps re-sending the frame.
module ir_sirc_tx #(
  parameter int UNIT_CYCLES    = 2024,
  parameter int CARRIER_PERIOD = 675,
  parameter int CARRIER_HIGH   = 169,
  parameter int MAX_BITS       = 20
) (
  input  logic        clk,
  input  logic        reset,
  ir_sirc_tx_if.slave bus,
  output logic        signal_out
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST   = CW'(CARRIER_PERIOD - 1);
  localparam logic [CW:0]   CAR_HIGH   = (CW+1)'(CARRIER_HIGH);
  localparam logic [4:0]    NB_MAX     = 5'(MAX_BITS);
  localparam logic [9:0]    FRAME_LAST = 10'd599;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SPACE = 3'd2,
    MARK  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]       pre_cnt;
  logic [CW-1:0]       carrier_cnt;
  logic [5:0]          units;
  logic [9:0]          elapsed;
  logic [MAX_BITS-1:0] data_lat;
  logic [MAX_BITS-1:0] data_sh;
  logic [4:0]          nbits_lat;
  logic [4:0]          bit_cnt;
  logic [3:0]          rpt_lat;
  logic [3:0]          rpt_cnt;
  logic                done_q;

  logic                unit_tick;
  logic [5:0]          dur;
  logic                state_end;
  logic                last_bit;
  logic                advance;
  logic                hold_go;
  logic [4:0]          nbits_in;

  // A held start only matters at the end of the final gap.
`ifdef IR_SIRC_TX_HOLD_EN
  assign hold_go = bus.start;
`else
  assign hold_go = 1'b0;
`endif

  assign nbits_in  = (bus.nbits == 5'd0 || bus.nbits > NB_MAX) ? NB_MAX : bus.nbits;
  assign unit_tick = (state != IDLE) && (pre_cnt == PRE_LAST);
  assign last_bit  = (5'(bit_cnt + 5'd1) == nbits_lat);
  assign advance   = (state_nxt != state);

  always_comb begin
    dur = 6'd8;
    case (state)
      HDR:     dur = 6'd32;
      MARK:    dur = data_sh[0] ? 6'd16 : 6'd8;
      default: dur = 6'd8;
    endcase
  end

  // GAP ends on frame length rather than its own unit count, so every frame is 600 units.
  always_comb begin
    state_end = 1'b0;
    if (unit_tick) begin
      if (state == GAP) state_end = (elapsed == FRAME_LAST);
      else              state_end = (units == 6'(dur - 6'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = HDR;
      HDR:   if (state_end) state_nxt = SPACE;
      SPACE: if (state_end) state_nxt = MARK;
      MARK:  if (state_end) state_nxt = last_bit ? GAP : SPACE;
      GAP: begin
        if (state_end) begin
          if (rpt_cnt != 4'd0 || hold_go) state_nxt = HDR;
          else                            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready  = (state == IDLE);
    bus.busy   = (state != IDLE);
    bus.done   = done_q;
    signal_out = ((state == HDR) || (state == MARK)) && ({1'b0, carrier_cnt} < CAR_HIGH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt     <= '0;
      carrier_cnt <= '0;
      units       <= '0;
      elapsed     <= '0;
      data_lat    <= '0;
      data_sh     <= '0;
      nbits_lat   <= '0;
      bit_cnt     <= '0;
      rpt_lat     <= '0;
      rpt_cnt     <= '0;
      done_q      <= 1'b0;
    end else begin
      carrier_cnt <= (carrier_cnt == CAR_LAST) ? '0 : CW'(carrier_cnt + 1'b1);

      if (advance || state == IDLE) begin
        pre_cnt <= '0;
        units   <= '0;
      end else begin
        pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : PW'(pre_cnt + 1'b1);
        if (unit_tick) units <= units + 6'd1;
      end

      if (advance && state_nxt == HDR) elapsed <= '0;
      else if (unit_tick)              elapsed <= elapsed + 10'd1;

      done_q <= (state == GAP) && (state_nxt == IDLE);

      case (state)
        IDLE: begin
          if (bus.start) begin
            data_lat  <= bus.data;
            data_sh   <= bus.data;
            nbits_lat <= nbits_in;
            rpt_lat   <= bus.repeats;
            rpt_cnt   <= bus.repeats;
            bit_cnt   <= '0;
          end
        end
        MARK: begin
          if (state_end) begin
            data_sh <= data_sh >> 1;
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        GAP: begin
          if (state_end) begin
            data_sh <= data_lat;
            bit_cnt <= '0;
            if (rpt_cnt != 4'd0) rpt_cnt <= rpt_cnt - 4'd1;
            else if (hold_go)    rpt_cnt <= rpt_lat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_sirc_tx.sv
// tb/tb_ir_sirc_tx.sv - scoreboard bench: decodes carrier bursts back into frames and checks timing
module tb_ir_sirc_tx;

  localparam int MB    = 20;
  localparam int FRAME = 2400;

  typedef struct packed {
    logic [MB-1:0] data;
    logic [4:0]    nbits;
    logic          first;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signal_out;

  ir_sirc_tx_if #(.MAX_BITS(MB)) bus();

  ir_sirc_tx #(
    .UNIT_CYCLES(4),
    .CARRIER_PERIOD(4),
    .CARRIER_HIGH(1),
    .MAX_BITS(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .signal_out(signal_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  frame_t exp_q[$];
  int     done_q[$];

  bit            in_burst = 1'b0;
  bit            have_frame = 1'b0;
  int            hi_cnt = 0;
  int            last_hi = 0;
  int            burst_start = 0;
  int            last_hdr = 0;
  int            bits_seen = 0;
  int            done_count = 0;
  logic [MB-1:0] got_data = '0;
  frame_t        cur;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [4:0] clampn(input logic [4:0] n);
    return (n == 5'd0 || n > 5'(MB)) ? 5'(MB) : n;
  endfunction

  function automatic logic [MB-1:0] low_mask(input logic [4:0] n);
    logic [MB-1:0] m;
    m = '0;
    for (int i = 0; i < MB; i++) if (i < int'(n)) m[i] = 1'b1;
    return m;
  endfunction

  // Burst of 32 carrier pulses = header, 16 = one, 8 = zero.
  task automatic end_burst();
    if (hi_cnt == 32) begin
      check("prev_frame_complete", have_frame, 0);
      check("hdr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (!cur.first) check("frame_period", burst_start - last_hdr, FRAME);
        last_hdr   = burst_start;
        have_frame = 1'b1;
        bits_seen  = 0;
        got_data   = '0;
      end
    end else if (hi_cnt == 16 || hi_cnt == 8) begin
      if (!have_frame) begin
        check("mark_outside_frame", 1, 0);
      end else begin
        got_data[bits_seen] = (hi_cnt == 16);
        bits_seen++;
        if (bits_seen == int'(cur.nbits)) begin
          check("frame_data", got_data, cur.data);
          have_frame = 1'b0;
        end
      end
    end else begin
      check("burst_len", hi_cnt, 8);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_burst   = 1'b0;
      have_frame = 1'b0;
    end else begin
      if (signal_out) begin
        if (!in_burst) begin
          in_burst    = 1'b1;
          hi_cnt      = 1;
          burst_start = cyc;
        end else begin
          check("carrier_spacing", cyc - last_hi, 4);
          hi_cnt++;
        end
        last_hi = cyc;
      end else if (in_burst && (cyc - last_hi) >= 8) begin
        in_burst = 1'b0;
        end_burst();
      end
      if (bus.done) begin
        done_count++;
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else                    check("done_time", cyc, done_q.pop_front());
      end
    end
  end

  task automatic send(input logic [MB-1:0] d, input logic [4:0] n, input logic [3:0] r,
                      input int frames, input bit hold);
    int w;
    logic [4:0] nb;
    w = 0;
    nb = clampn(n);
    @(negedge clk);
    while (!bus.ready && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_start", bus.ready, 1);
    bus.data    = d;
    bus.nbits   = n;
    bus.repeats = r;
    bus.start   = 1'b1;
    for (int i = 0; i < frames; i++)
      exp_q.push_back('{data: d & low_mask(nb), nbits: nb, first: (i == 0)});
    done_q.push_back(cyc + 1 + FRAME * frames);
    @(negedge clk);
    check("ready_after_accept", bus.ready, 0);
    check("busy_after_accept", bus.busy, 1);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((!bus.ready || done_q.size() != 0) && w < 30000) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", bus.ready, 1);
  endtask

  initial begin
    int dc;
    bus.data    = '0;
    bus.nbits   = '0;
    bus.repeats = '0;
    bus.start   = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", bus.ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_signal", signal_out, 0);

    send(20'h00001, 5'd12, 4'd0, 1, 1'b0);
    send(20'hFFFFF, 5'd20, 4'd2, 3, 1'b0);
    send(20'hA5A5A, 5'd0,  4'd0, 1, 1'b0);
    send(20'h3C96F, 5'd25, 4'd0, 1, 1'b0);

    send(20'h5A3C1, 5'd17, 4'd0, 1, 1'b0);
    repeat (300) @(negedge clk);
    bus.data    = 20'h0F0F0;
    bus.nbits   = 5'd7;
    bus.repeats = 4'd5;
    bus.start   = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_ignores_start", bus.ready, 0);
    bus.start = 1'b0;

    for (int k = 0; k < 2; k++)
      send(MB'($urandom), 5'($urandom_range(1, MB)), 4'd1, 2, 1'b0);
    wait_idle();

    send(20'hFFFFF, 5'd20, 4'd0, 1, 1'b0);
    repeat (180) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    dc = done_count;
    @(negedge clk);
    check("midframe_reset_signal", signal_out, 0);
    check("midframe_reset_ready", bus.ready, 1);
    reset = 1'b0;
    repeat (3000) @(negedge clk);
    check("no_done_after_reset", done_count - dc, 0);

`ifdef IR_SIRC_TX_HOLD_EN
    send(20'h00ABC, 5'd12, 4'd0, 3, 1'b1);
    repeat (2 * FRAME + 100) @(negedge clk);
    check("hold_still_busy", bus.ready, 0);
    bus.start = 1'b0;
`endif

    wait_idle();
    repeat (20) @(negedge clk);
    check("frames_left", exp_q.size(), 0);
    check("done_left", done_q.size(), 0);
    check("frame_open", have_frame, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
